// File: rtl/sem_byte_assembler_pkg.sv
// Shared types for the semaphore byte assembler.
//   asm_state_t : reader FSM states (IDLE -> TAKE -> GAP -> IDLE)
//   SEM_WORD_W  : default assembled word width
package sem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    GAP  = 2'd2
  } asm_state_t;

  localparam int SEM_WORD_W = 8;

endpackage

// File: rtl/sem_byte_assembler_if.sv
// Bus bundle for sem_byte_assembler.
//   sema_* : one-bit storage side (empty flag, stored bit, consume pulse)
//   byte_* : valid/ready word output
//   flush_i, bit_count_o : partial-word control/status
// master = assembler side, slave = storage/consumer side.
interface sem_byte_assembler_if
  import sem_pkg::*;
#(
  parameter int WIDTH = SEM_WORD_W
) ();

  localparam int CW = $clog2(WIDTH + 1);

  logic             sema_is_empty_i_s;
  logic             sema_data_i_s;
  logic             sema_ready_o_s;
  logic             flush_i;
  logic [WIDTH-1:0] byte_data_o;
  logic             byte_valid_o;
  logic             byte_ready_i;
  logic [CW-1:0]    bit_count_o;

  modport master (
    input  sema_is_empty_i_s, sema_data_i_s, flush_i, byte_ready_i,
    output sema_ready_o_s, byte_data_o, byte_valid_o, bit_count_o
  );

  modport slave (
    output sema_is_empty_i_s, sema_data_i_s, flush_i, byte_ready_i,
    input  sema_ready_o_s, byte_data_o, byte_valid_o, bit_count_o
  );

endinterface

// File: rtl/sem_byte_assembler_shift_in.sv
// Shift register plus bit counter for the partial word.
//   shift_en : shift bit_i in and bump count
//   clear    : zero register and count (wins over shift_en)
//   word     : register with bit_i already shifted in (combinational), so
//              the top can load a completed word on the edge the last bit
//              arrives without an extra cycle
//   count    : bits currently held
module sem_shift_in
  import sem_pkg::*;
#(
  parameter int WIDTH     = SEM_WORD_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_i,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;

  generate
    if (MSB_FIRST) begin : g_msb
      // first bit received ends up in WIDTH-1
      assign sr_shift = {sr[WIDTH-2:0], bit_i};
    end else begin : g_lsb
      // first bit received ends up in 0
      assign sr_shift = {bit_i, sr[WIDTH-1:1]};
    end
  endgenerate

  assign word = sr_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr    <= '0;
      count <= '0;
    end else if (clear) begin
      sr    <= '0;
      count <= '0;
    end else if (shift_en) begin
      sr    <= sr_shift;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sem_byte_assembler.sv
// Reader end of the semaphore one-bit storage. Consumes each stored bit
// with a one-cycle sema_ready_o_s pulse, assembles WIDTH-bit words and
// presents them on a valid/ready port.
//   clk_s, rst_s : clock, async active-high reset
//   bus          : sema_* storage side, byte_* output, flush_i, bit_count_o
// The FSM spends IDLE -> TAKE -> GAP per bit; GAP gives the storage flag
// a cycle to clear so a bit is never consumed twice.
module sem_byte_assembler
  import sem_pkg::*;
#(
  parameter int WIDTH     = SEM_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk_s,
  input  logic                 rst_s,
  sem_byte_assembler_if.master bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  asm_state_t       state, state_nxt;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;
  logic             take;
  logic             last_bit;
  logic             slot_free;
  logic             take_ok;
  logic             shift_en;
  logic             clear;
  logic             load;

  assign take      = (state == TAKE);
  assign last_bit  = (count == LAST);
  assign slot_free = !bus.byte_valid_o || bus.byte_ready_i;
  // Only the word-completing bit needs a free slot; earlier bits can
  // always be absorbed, so back-pressure leaves just the last bit stored.
  assign take_ok   = (count < LAST) || slot_free;

  assign shift_en  = take && !last_bit && !bus.flush_i;
  assign load      = take &&  last_bit && !bus.flush_i;
  // A flush during TAKE still consumes the bit; it just never lands.
  assign clear     = bus.flush_i || (take && last_bit);

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.sema_is_empty_i_s && take_ok) state_nxt = TAKE;
      TAKE:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output: drops asynchronously with the state register on reset.
  assign bus.sema_ready_o_s = take;

  sem_shift_in #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_shift (
    .clk      (clk_s),
    .rst      (rst_s),
    .shift_en (shift_en),
    .bit_i    (bus.sema_data_i_s),
    .clear    (clear),
    .word     (word),
    .count    (count)
  );

  assign bus.bit_count_o = count;

  // Output register: a load can only happen when the slot was free at
  // IDLE, and the GAP/IDLE cycles in between keep load and transfer from
  // colliding with a still-unaccepted word.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      bus.byte_data_o  <= '0;
      bus.byte_valid_o <= 1'b0;
    end else if (load) begin
      bus.byte_data_o  <= word;
      bus.byte_valid_o <= 1'b1;
    end else if (bus.byte_valid_o && bus.byte_ready_i) begin
      bus.byte_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sem_byte_assembler.sv
module tb_sem_byte_assembler;
  import sem_pkg::*;

  logic clk_s = 1'b0;
  logic rst_s = 1'b1;
  always #5 clk_s = ~clk_s;

  sem_byte_assembler_if #(.WIDTH(8)) ifa ();
  sem_byte_assembler_if #(.WIDTH(8)) ifb ();

  sem_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk_s (clk_s), .rst_s (rst_s), .bus (ifa.master));
  sem_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk_s (clk_s), .rst_s (rst_s), .bus (ifb.master));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk_s) cyc <= cyc + 1;

  // ---- one-bit storage models: initial pushes, model walks an index ----
  bit   qa[$];
  bit   qb[$];
  int   ia = 0, ib = 0;
  logic full_a, data_a, full_b, data_b;

  always @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      full_a <= 1'b0; data_a <= 1'b0; ia <= qa.size();
    end else if (ifa.sema_ready_o_s) begin
      full_a <= 1'b0;
    end else if (!full_a && ia < qa.size()) begin
      full_a <= 1'b1; data_a <= qa[ia]; ia <= ia + 1;
    end
  end

  always @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      full_b <= 1'b0; data_b <= 1'b0; ib <= qb.size();
    end else if (ifb.sema_ready_o_s) begin
      full_b <= 1'b0;
    end else if (!full_b && ib < qb.size()) begin
      full_b <= 1'b1; data_b <= qb[ib]; ib <= ib + 1;
    end
  end

  assign ifa.sema_is_empty_i_s = !full_a;
  assign ifa.sema_data_i_s     = data_a;
  assign ifb.sema_is_empty_i_s = !full_b;
  assign ifb.sema_data_i_s     = data_b;

  // ---- monitors ----
  logic [7:0] rxa[$];
  logic [7:0] rxb[$];
  always @(posedge clk_s) begin
    if (ifa.byte_valid_o && ifa.byte_ready_i) rxa.push_back(ifa.byte_data_o);
    if (ifb.byte_valid_o && ifb.byte_ready_i) rxb.push_back(ifb.byte_data_o);
  end

  int pulses_a = 0, vhigh_a = 0, cons_err = 0, stab_err = 0;
  int last_take_a = 0, first_valid_a = 0;
  logic prev_rdy_a = 0, prev_rdy_b = 0, prev_v_a = 0, prev_br_a = 0;
  logic [7:0] prev_d_a = '0;
  always @(negedge clk_s) begin
    if (ifa.sema_ready_o_s) begin
      pulses_a    <= pulses_a + 1;
      last_take_a <= cyc;
      if (prev_rdy_a) cons_err <= cons_err + 1;
    end
    if (ifb.sema_ready_o_s && prev_rdy_b) cons_err <= cons_err + 1;
    if (ifa.byte_valid_o) vhigh_a <= vhigh_a + 1;
    if (ifa.byte_valid_o && !prev_v_a) first_valid_a <= cyc;
    if (prev_v_a && !prev_br_a && ifa.byte_valid_o && ifa.byte_data_o !== prev_d_a)
      stab_err <= stab_err + 1;
    prev_rdy_a <= ifa.sema_ready_o_s;
    prev_rdy_b <= ifb.sema_ready_o_s;
    prev_v_a   <= ifa.byte_valid_o;
    prev_br_a  <= ifa.byte_ready_i;
    prev_d_a   <= ifa.byte_data_o;
  end

  task automatic drive_tick();
    @(posedge clk_s); #1;
  endtask

  // seq[7] is the first bit presented
  task automatic push_a(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) qa.push_back(seq[7-i]);
  endtask

  task automatic push_b(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) qb.push_back(seq[7-i]);
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    ifa.byte_ready_i = 1'b1; ifa.flush_i = 1'b0;
    ifb.byte_ready_i = 1'b1; ifb.flush_i = 1'b0;
    rst_s = 1'b1;
    repeat (3) drive_tick();
    rst_s = 1'b0;
    @(negedge clk_s);
    nvec++; if (ifa.sema_ready_o_s !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b exp 0", ifa.sema_ready_o_s); end
    nvec++; if (ifa.byte_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", ifa.byte_valid_o); end
    nvec++; if (ifa.byte_data_o !== 8'h00) begin nerr++; $display("FAIL reset_data got %h exp 00", ifa.byte_data_o); end
    nvec++; if (ifa.bit_count_o !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", ifa.bit_count_o); end
    nvec++; if (ifb.byte_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid_b got %b exp 0", ifb.byte_valid_o); end
  endtask

  task automatic test_msb_first();
    int r0, p0, v0;
    r0 = rxa.size(); p0 = pulses_a; v0 = vhigh_a;
    push_a(8'hA5, 8);
    for (int i = 0; i < 200 && rxa.size() == r0; i++) @(negedge clk_s);
    repeat (5) @(negedge clk_s);
    nvec++; if (rxa.size() - r0 != 1) begin nerr++; $display("FAIL msb_word_count got %0d exp 1", rxa.size() - r0); end
    nvec++; if (rxa.size() <= r0 || rxa[r0] !== 8'hA5) begin nerr++; $display("FAIL msb_word got %h exp a5", (rxa.size() > r0) ? rxa[r0] : 8'hxx); end
    nvec++; if (pulses_a - p0 != 8) begin nerr++; $display("FAIL msb_pulses got %0d exp 8", pulses_a - p0); end
    nvec++; if (vhigh_a - v0 != 1) begin nerr++; $display("FAIL msb_valid_len got %0d exp 1", vhigh_a - v0); end
    nvec++; if (first_valid_a - last_take_a != 1) begin nerr++; $display("FAIL msb_latency got %0d exp 1", first_valid_a - last_take_a); end
    nvec++; if (cons_err != 0) begin nerr++; $display("FAIL ready_spacing got %0d exp 0", cons_err); end
  endtask

  task automatic test_lsb_first();
    int r0;
    r0 = rxb.size();
    push_b(8'hA5, 8);
    push_b(8'hC0, 8);
    for (int i = 0; i < 400 && rxb.size() < r0 + 2; i++) @(negedge clk_s);
    nvec++; if (rxb.size() - r0 != 2) begin nerr++; $display("FAIL lsb_word_count got %0d exp 2", rxb.size() - r0); end
    nvec++; if (rxb.size() <= r0 || rxb[r0] !== 8'hA5) begin nerr++; $display("FAIL lsb_word0 got %h exp a5", (rxb.size() > r0) ? rxb[r0] : 8'hxx); end
    nvec++; if (rxb.size() <= r0 + 1 || rxb[r0+1] !== 8'h03) begin nerr++; $display("FAIL lsb_word1 got %h exp 03", (rxb.size() > r0 + 1) ? rxb[r0+1] : 8'hxx); end
  endtask

  task automatic test_backpressure();
    int r0, p0;
    drive_tick(); ifa.byte_ready_i = 1'b0;
    r0 = rxa.size(); p0 = pulses_a;
    push_a(8'h3C, 8);
    push_a(8'h96, 8);
    for (int i = 0; i < 400 && !(ifa.bit_count_o == 4'd7 && pulses_a - p0 == 15); i++)
      @(negedge clk_s);
    repeat (10) @(negedge clk_s);
    nvec++; if (ifa.byte_valid_o !== 1'b1) begin nerr++; $display("FAIL bp_valid got %b exp 1", ifa.byte_valid_o); end
    nvec++; if (ifa.byte_data_o !== 8'h3C) begin nerr++; $display("FAIL bp_data got %h exp 3c", ifa.byte_data_o); end
    nvec++; if (ifa.bit_count_o !== 4'd7) begin nerr++; $display("FAIL bp_count got %0d exp 7", ifa.bit_count_o); end
    nvec++; if (ifa.sema_is_empty_i_s !== 1'b0) begin nerr++; $display("FAIL bp_flag got %b exp 0", ifa.sema_is_empty_i_s); end
    nvec++; if (pulses_a - p0 != 15) begin nerr++; $display("FAIL bp_pulses got %0d exp 15", pulses_a - p0); end
    nvec++; if (stab_err != 0) begin nerr++; $display("FAIL bp_stable got %0d exp 0", stab_err); end
    drive_tick(); ifa.byte_ready_i = 1'b1;
    for (int i = 0; i < 100 && rxa.size() < r0 + 2; i++) @(negedge clk_s);
    nvec++; if (rxa.size() - r0 != 2) begin nerr++; $display("FAIL bp_word_count got %0d exp 2", rxa.size() - r0); end
    nvec++; if (rxa.size() <= r0 || rxa[r0] !== 8'h3C) begin nerr++; $display("FAIL bp_word0 got %h exp 3c", (rxa.size() > r0) ? rxa[r0] : 8'hxx); end
    nvec++; if (rxa.size() <= r0 + 1 || rxa[r0+1] !== 8'h96) begin nerr++; $display("FAIL bp_word1 got %h exp 96", (rxa.size() > r0 + 1) ? rxa[r0+1] : 8'hxx); end
    nvec++; if (pulses_a - p0 != 16) begin nerr++; $display("FAIL bp_total_pulses got %0d exp 16", pulses_a - p0); end
  endtask

  task automatic test_flush();
    int r0, p0;
    r0 = rxa.size(); p0 = pulses_a;
    push_a(8'hE0, 3);
    for (int i = 0; i < 100 && pulses_a - p0 < 3; i++) @(negedge clk_s);
    repeat (4) @(negedge clk_s);
    nvec++; if (ifa.bit_count_o !== 4'd3) begin nerr++; $display("FAIL flush_pre_count got %0d exp 3", ifa.bit_count_o); end
    drive_tick(); ifa.flush_i = 1'b1;
    drive_tick(); ifa.flush_i = 1'b0;
    @(negedge clk_s);
    nvec++; if (ifa.bit_count_o !== 4'd0) begin nerr++; $display("FAIL flush_count got %0d exp 0", ifa.bit_count_o); end
    push_a(8'h81, 8);
    for (int i = 0; i < 200 && rxa.size() == r0; i++) @(negedge clk_s);
    nvec++; if (rxa.size() <= r0 || rxa[r0] !== 8'h81) begin nerr++; $display("FAIL flush_word got %h exp 81", (rxa.size() > r0) ? rxa[r0] : 8'hxx); end
  endtask

  task automatic test_reset_mid();
    int r0;
    bit hit;
    drive_tick(); ifa.byte_ready_i = 1'b0;
    push_a(8'hFF, 8);
    push_a(8'hFF, 8);
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk_s);
      hit = ifa.sema_ready_o_s && ifa.bit_count_o == 4'd5 && ifa.byte_valid_o;
    end
    nvec++; if (!hit) begin nerr++; $display("FAIL rstmid_reach got 0 exp 1"); end
    #2 rst_s = 1'b1;
    #1;
    nvec++; if (ifa.sema_ready_o_s !== 1'b0) begin nerr++; $display("FAIL rstmid_ready got %b exp 0", ifa.sema_ready_o_s); end
    nvec++; if (ifa.byte_valid_o !== 1'b0) begin nerr++; $display("FAIL rstmid_valid got %b exp 0", ifa.byte_valid_o); end
    nvec++; if (ifa.bit_count_o !== 4'd0) begin nerr++; $display("FAIL rstmid_count got %0d exp 0", ifa.bit_count_o); end
    repeat (2) drive_tick();
    rst_s = 1'b0; ifa.byte_ready_i = 1'b1;
    r0 = rxa.size();
    push_a(8'h5A, 8);
    for (int i = 0; i < 200 && rxa.size() == r0; i++) @(negedge clk_s);
    repeat (5) @(negedge clk_s);
    nvec++; if (rxa.size() - r0 != 1) begin nerr++; $display("FAIL rstmid_word_count got %0d exp 1", rxa.size() - r0); end
    nvec++; if (rxa.size() <= r0 || rxa[r0] !== 8'h5A) begin nerr++; $display("FAIL rstmid_word got %h exp 5a", (rxa.size() > r0) ? rxa[r0] : 8'hxx); end
  endtask

  task automatic test_random_ready();
    logic [7:0] exp_w[$];
    int r0;
    r0 = rxa.size();
    for (int i = 0; i < 200; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      exp_w.push_back(w);
      push_a(w, 8);
    end
    for (int i = 0; i < 30000 && rxa.size() < r0 + 200; i++) begin
      drive_tick();
      ifa.byte_ready_i = 1'($urandom_range(0, 1));
    end
    drive_tick(); ifa.byte_ready_i = 1'b1;
    repeat (5) @(negedge clk_s);
    nvec++; if (rxa.size() - r0 != 200) begin nerr++; $display("FAIL rand_word_count got %0d exp 200", rxa.size() - r0); end
    for (int i = 0; i < 200; i++) begin
      nvec++;
      if (rxa.size() <= r0 + i || rxa[r0+i] !== exp_w[i]) begin
        nerr++;
        $display("FAIL rand_word[%0d] got %h exp %h", i, (rxa.size() > r0 + i) ? rxa[r0+i] : 8'hxx, exp_w[i]);
      end
    end
    nvec++; if (stab_err != 0) begin nerr++; $display("FAIL rand_stable got %0d exp 0", stab_err); end
    nvec++; if (cons_err != 0) begin nerr++; $display("FAIL rand_spacing got %0d exp 0", cons_err); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_ready();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
